// File: rtl/result_sender.sv
// -----------------------------------------------------------------------------
// result_sender
//
// Sends the result array to the host. After the execute phase it reads the
// ELEM_W-bit result array two elements at a time and packs each pair into one
// 2*ELEM_W-bit word for the host-read FIFO. The FIFO's read side feeds the
// Xillybus read_32 stream. Element 2k goes to the low half of word k and
// element 2k+1 goes to the high half, which matches the receive path.
//
// Ports
//   bus_clk       : sole clock, rising edge
//   bus_rst_n     : asynchronous active-low reset
//   start         : one-cycle request to begin a transfer (honoured in IDLE only)
//   clear         : synchronous abort, highest synchronous priority
//   elem_rd       : element read strobe (combinational from state and clear)
//   elem_addr     : element address, meaningful only while elem_rd = 1
//   elem_data     : element value, valid the cycle after elem_rd = 1
//   send_enabled  : host-read FIFO write enable (combinational)
//   send_data     : packed word {hi, lo}
//   send_full     : host-read FIFO full
//   busy          : high in every state except IDLE
//   done          : one-cycle pulse after the final word is written
//   words_sent    : number of words written in the current or last transfer
//
// Handshake: send_enabled/send_full use the usual FIFO wr_en/full
// semantics. A word is transferred in exactly the cycles where
// send_enabled = 1, and send_enabled is never high while send_full = 1.
// send_full is sampled in the same cycle it applies. While the FIFO is
// full, the FSM waits in WR and send_data stays stable.
// -----------------------------------------------------------------------------
module result_sender #(
    parameter int N_ELEM = 512,
    parameter int ADDR_W = 9,
    parameter int ELEM_W = 16
) (
    input  logic                bus_clk,
    input  logic                bus_rst_n,
    input  logic                start,
    input  logic                clear,
    output logic                elem_rd,
    output logic [ADDR_W-1:0]   elem_addr,
    input  logic [ELEM_W-1:0]   elem_data,
    output logic                send_enabled,
    output logic [2*ELEM_W-1:0] send_data,
    input  logic                send_full,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   words_sent
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        CAP_HI = 3'd3,
        WR     = 3'd4
    } state_t;

    // Index of the final word. The compare is exact, so word_idx never wraps.
    localparam logic [ADDR_W-2:0] LAST_IDX = (ADDR_W-1)'(N_ELEM/2 - 1);

    state_t              state;
    logic [ADDR_W-2:0]   word_idx;
    logic [ELEM_W-1:0]   lo_reg;
    logic [ELEM_W-1:0]   hi_reg;

    // The strobes come straight from state, so clear can suppress them in the
    // same cycle. An aborted transfer therefore never writes a partial word.
    assign elem_rd      = !clear && ((state == RD_LO) || (state == RD_HI));
    assign send_enabled = !clear && (state == WR) && !send_full;

    // The packed word is taken directly from the capture registers. It stays
    // stable for the whole time WR waits on a full FIFO.
    assign send_data    = {hi_reg, lo_reg};

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state      <= IDLE;
            word_idx   <= '0;
            lo_reg     <= '0;
            hi_reg     <= '0;
            elem_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            words_sent <= '0;
        end else if (clear) begin
            // Abort: words_sent keeps the count of words already written.
            state    <= IDLE;
            word_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        word_idx   <= '0;
                        words_sent <= '0;
                        elem_addr  <= '0;
                        busy       <= 1'b1;
                        state      <= RD_LO;
                    end
                end
                RD_LO: begin
                    // elem_addr is registered, so the high-element address is
                    // loaded here for use in the RD_HI cycle.
                    elem_addr <= {word_idx, 1'b1};
                    state     <= RD_HI;
                end
                RD_HI: begin
                    // Returns the data for the RD_LO read.
                    lo_reg <= elem_data;
                    state  <= CAP_HI;
                end
                CAP_HI: begin
                    // Returns the data for the RD_HI read.
                    hi_reg <= elem_data;
                    state  <= WR;
                end
                WR: begin
                    if (!send_full) begin
                        words_sent <= words_sent + 1'b1;
                        if (word_idx == LAST_IDX) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            word_idx  <= word_idx + 1'b1;
                            elem_addr <= {word_idx + 1'b1, 1'b0};
                            state     <= RD_LO;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
